cc_branch_cond: RTL

- Consumer side of the processor status register: reads the registered NZVC word and evaluates a 4-bit branch condition field.
- Produces a registered taken/not-taken decision and the next fetch address for the control unit / microsequencer.
- Sits between the PSR output and the PC-select logic. Uses a valid/ready handshake on both sides and a one-entry output buffer.

---
 rtl/cc_branch_pkg.sv | 32 +++
 rtl/cc_branch_cond_if.sv | 44 ++++
 rtl/cc_cond_eval.sv | 41 ++++
 rtl/cc_branch_cond.sv | 68 ++++++
 4 files changed

// File: rtl/cc_branch_pkg.sv
// Shared definitions for the branch-condition block: condition codes, PSR flag
// bit positions and the output-buffer FSM encoding.
package cc_branch_pkg;

  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  localparam int IDX_N = 3;
  localparam int IDX_Z = 2;
  localparam int IDX_V = 1;
  localparam int IDX_C = 0;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/cc_branch_cond_if.sv
// Request/decision bus of cc_branch_cond. The flag-forwarding signals exist
// only when CC_BRANCH_BYPASS_EN is defined.
interface cc_branch_cond_if #(
  parameter int DATAWIDTH_ADDR = 32,
  parameter int DATAWIDTH_CNT  = 16
);

  logic [3:0]                CC_BRANCH_PSR_IN;
  logic [3:0]                CC_BRANCH_COND;
  logic [DATAWIDTH_ADDR-1:0] CC_BRANCH_TARGET;
  logic [DATAWIDTH_ADDR-1:0] CC_BRANCH_FALLTHRU;
  logic                      CC_BRANCH_REQ_VALID;
  logic                      CC_BRANCH_REQ_READY;
  logic                      CC_BRANCH_OUT_VALID;
  logic                      CC_BRANCH_OUT_READY;
  logic                      CC_BRANCH_TAKEN;
  logic [DATAWIDTH_ADDR-1:0] CC_BRANCH_NEXT_ADDR;
  logic [DATAWIDTH_CNT-1:0]  CC_BRANCH_TAKEN_CNT;
`ifdef CC_BRANCH_BYPASS_EN
  logic                      CC_BRANCH_SET_COND;
  logic [3:0]                CC_BRANCH_FLAGS_IN;
`endif

  modport master (
    output CC_BRANCH_PSR_IN, CC_BRANCH_COND, CC_BRANCH_TARGET, CC_BRANCH_FALLTHRU,
    output CC_BRANCH_REQ_VALID, CC_BRANCH_OUT_READY,
`ifdef CC_BRANCH_BYPASS_EN
    output CC_BRANCH_SET_COND, CC_BRANCH_FLAGS_IN,
`endif
    input  CC_BRANCH_REQ_READY, CC_BRANCH_OUT_VALID, CC_BRANCH_TAKEN,
    input  CC_BRANCH_NEXT_ADDR, CC_BRANCH_TAKEN_CNT
  );

  modport slave (
    input  CC_BRANCH_PSR_IN, CC_BRANCH_COND, CC_BRANCH_TARGET, CC_BRANCH_FALLTHRU,
    input  CC_BRANCH_REQ_VALID, CC_BRANCH_OUT_READY,
`ifdef CC_BRANCH_BYPASS_EN
    input  CC_BRANCH_SET_COND, CC_BRANCH_FLAGS_IN,
`endif
    output CC_BRANCH_REQ_READY, CC_BRANCH_OUT_VALID, CC_BRANCH_TAKEN,
    output CC_BRANCH_NEXT_ADDR, CC_BRANCH_TAKEN_CNT
  );

endinterface

// File: rtl/cc_cond_eval.sv
// Combinational branch-condition evaluator: {N,Z,V,C} flags and a 4-bit
// condition code in, taken out. Kept standalone for reuse by other units.
module cc_cond_eval
  import cc_branch_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n, z, v, c;

  assign n = flags[IDX_N];
  assign z = flags[IDX_Z];
  assign v = flags[IDX_V];
  assign c = flags[IDX_C];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BA:   taken = 1'b1;
      COND_BN:   taken = 1'b0;
      COND_BNE:  taken = ~z;
      COND_BE:   taken = z;
      COND_BG:   taken = ~(z | (n ^ v));
      COND_BLE:  taken = z | (n ^ v);
      COND_BGE:  taken = ~(n ^ v);
      COND_BL:   taken = n ^ v;
      COND_BGU:  taken = ~(c | z);
      COND_BLEU: taken = c | z;
      COND_BCC:  taken = ~c;
      COND_BCS:  taken = c;
      COND_BPOS: taken = ~n;
      COND_BNEG: taken = n;
      COND_BVC:  taken = ~v;
      COND_BVS:  taken = v;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_branch_cond.sv
// Branch decision unit: evaluates a condition against the PSR flags and holds the
// result in a one-entry output buffer. CC_BRANCH_BYPASS_EN adds flag forwarding.
module cc_branch_cond
  import cc_branch_pkg::*;
#(
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_ADDR          = 32,
  parameter int DATAWIDTH_CNT           = 16
) (
  input  logic             CC_BRANCH_CLOCK_50,
  input  logic             CC_BRANCH_RESET_InLow,
  cc_branch_cond_if.slave  bus
);

  localparam logic [DATAWIDTH_CNT-1:0] CNT_MAX = {DATAWIDTH_CNT{1'b1}};
  localparam logic [DATAWIDTH_CNT-1:0] CNT_ONE = DATAWIDTH_CNT'(1);

  state_t                       state;
  logic                         taken_q;
  logic [DATAWIDTH_ADDR-1:0]    next_addr_q;
  logic [DATAWIDTH_CNT-1:0]     taken_cnt_q;
  logic [DATAWIDTH_ALU_SELECTION-1:0] eval_flags;
  logic                         eval_taken;
  logic                         req_ready;
  logic                         accept;

  // Forwarded ALU flags win over the PSR so a branch right after a flag-setting op sees the new flags.
`ifdef CC_BRANCH_BYPASS_EN
  assign eval_flags = bus.CC_BRANCH_SET_COND ? bus.CC_BRANCH_FLAGS_IN : bus.CC_BRANCH_PSR_IN;
`else
  assign eval_flags = bus.CC_BRANCH_PSR_IN;
`endif

  cc_cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (bus.CC_BRANCH_COND),
    .taken (eval_taken)
  );

  assign req_ready = (state == IDLE) | bus.CC_BRANCH_OUT_READY;
  assign accept    = bus.CC_BRANCH_REQ_VALID & req_ready;

  // A new request may replace the held result in the same cycle it is consumed.
  always_ff @(posedge CC_BRANCH_CLOCK_50 or negedge CC_BRANCH_RESET_InLow) begin
    if (!CC_BRANCH_RESET_InLow) begin
      state       <= IDLE;
      taken_q     <= 1'b0;
      next_addr_q <= '0;
      taken_cnt_q <= '0;
    end else if (accept) begin
      state       <= FULL;
      taken_q     <= eval_taken;
      next_addr_q <= eval_taken ? bus.CC_BRANCH_TARGET : bus.CC_BRANCH_FALLTHRU;
      if (eval_taken && (taken_cnt_q != CNT_MAX)) begin
        taken_cnt_q <= taken_cnt_q + CNT_ONE;
      end
    end else if ((state == FULL) && bus.CC_BRANCH_OUT_READY) begin
      state <= IDLE;
    end
  end

  assign bus.CC_BRANCH_REQ_READY = req_ready;
  assign bus.CC_BRANCH_OUT_VALID = (state == FULL);
  assign bus.CC_BRANCH_TAKEN     = taken_q;
  assign bus.CC_BRANCH_NEXT_ADDR = next_addr_q;
  assign bus.CC_BRANCH_TAKEN_CNT = taken_cnt_q;

endmodule
